// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int DEF_BAUD_CNT = 5208;  // 50 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// FIFO write-side handshake plus error strobes of the UART receiver.
// Optional parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 full;
  logic                 wr_en;
  logic [DATA_BITS-1:0] data;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (input full, output wr_en, data, frame_err, overrun, parity_err);
  modport slave  (output full, input wr_en, data, frame_err, overrun, parity_err);
`else
  modport master (input full, output wr_en, data, frame_err, overrun);
  modport slave  (output full, input wr_en, data, frame_err, overrun);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser with falling-edge detect for an asynchronous input.
// Flops reset to 1 so an idle-high line produces no spurious edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rxd_s,
  output logic fall
);

  logic meta, rxd_s_d;

  // metastability stage, synchronised sample, and its one-cycle delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_s_d <= 1'b1;
    end else begin
      meta    <= din;
      rxd_s   <= meta;
      rxd_s_d <= rxd_s;
    end
  end

  assign fall = rxd_s_d & ~rxd_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples at bit centres, pushes good bytes to a FIFO.
// Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
`ifdef UART_RX_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  parameter int BAUD_CNT   = DEF_BAUD_CNT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      RXD,
  uart_rx_if.master fifo
);

  localparam int            CW      = $clog2(BAUD_CNT);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_CNT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_CNT - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t     POST_DATA = PARITY;
`else
  localparam rx_state_t     POST_DATA = STOP;
`endif

  rx_state_t            state, nxt;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_num;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_s, fall;
  logic                 bit_tick, mid_tick;
  logic                 do_wr, do_ferr, do_ovr;
  logic                 par_bad;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (RXD),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  assign bit_tick = (cnt == FULL_M1);
  assign mid_tick = (cnt == HALF_M1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state and stop-bit verdict
  always_comb begin
    nxt     = state;
    do_wr   = 1'b0;
    do_ferr = 1'b0;
    do_ovr  = 1'b0;
    case (state)
      IDLE:   if (fall) nxt = START;
      START:  if (mid_tick) nxt = rxd_s ? IDLE : DATA;
      DATA:   if (bit_tick && bit_num == 3'd7) nxt = POST_DATA;
      PARITY: if (bit_tick) nxt = STOP;
      STOP: begin
        // leave at mid-stop so a back-to-back start edge is still seen
        if (bit_tick) begin
          nxt = IDLE;
          if (!rxd_s)          do_ferr = 1'b1;
          else if (!par_bad) begin
            if (fifo.full)     do_ovr  = 1'b1;
            else               do_wr   = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // bit timer restarts on every state change; idle holds it at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (nxt != state)     cnt <= '0;
    else if (state != IDLE)    cnt <= cnt + 1'b1;
  end

  // data bit index and right-shifting assembly register (LSB arrives first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_num <= '0;
      shreg   <= '0;
    end else if (state != DATA) begin
      bit_num <= '0;
    end else if (bit_tick) begin
      shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
      if (bit_num != 3'd7) bit_num <= bit_num + 3'd1;
    end
  end

  // registered outputs: strobes land one cycle after the stop sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo.wr_en     <= 1'b0;
      fifo.data      <= '0;
      fifo.frame_err <= 1'b0;
      fifo.overrun   <= 1'b0;
    end else begin
      fifo.wr_en     <= do_wr;
      fifo.frame_err <= do_ferr;
      fifo.overrun   <= do_ovr;
      if (do_wr) fifo.data <= shreg;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_mis;
  assign par_mis = rxd_s ^ (^shreg) ^ PARITY_ODD;

  // parity verdict held until the stop bit; cleared for each new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad         <= 1'b0;
      fifo.parity_err <= 1'b0;
    end else begin
      fifo.parity_err <= (state == PARITY) && bit_tick && par_mis;
      if (state == START)                     par_bad <= 1'b0;
      else if (state == PARITY && bit_tick)   par_bad <= par_mis;
    end
  end
`else
  assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a frame-level expectation model.
module tb_uart_rx;

  localparam int BC = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  uart_rx_if u_if ();

  uart_rx #(.BAUD_CNT(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RXD   (rxd),
    .fifo  (u_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // observed side
  logic [7:0] got_q[$];
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  // expected side
  logic [7:0] exp_q[$];
  int e_ferr = 0, e_ovr = 0, e_perr = 0;
  logic [7:0] exp_data = 8'h00;

  // record every strobe cycle just after the active edge
  always @(posedge clk) begin
    #1;
    if (u_if.wr_en)     got_q.push_back(u_if.data);
    if (u_if.frame_err) n_ferr++;
    if (u_if.overrun)   n_ovr++;
`ifdef UART_RX_PARITY_EN
    if (u_if.parity_err) n_perr++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BC) @(negedge clk);
  endtask

  // start, 8 data LSB first, optional parity, stop
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`endif
    send_bit(stop);
  endtask

  // what a frame must produce, from the receive rules
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic full,
                             input logic pflip);
    logic pbad;
    pbad = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad = pflip;
    if (pflip) e_perr++;
`endif
    if (!stop)      e_ferr++;
    else if (pbad)  ;
    else if (full)  e_ovr++;
    else begin
      exp_q.push_back(d);
      exp_data = d;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":n_wr"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, ":wr_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    chk({tag, ":frame_err"}, n_ferr, e_ferr);
    chk({tag, ":overrun"},   n_ovr,  e_ovr);
    chk({tag, ":data"},      u_if.data, exp_data);
`ifdef UART_RX_PARITY_EN
    chk({tag, ":parity_err"}, n_perr, e_perr);
`endif
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input logic full,
                       input logic pflip);
    u_if.full = full;
    model_frame(d, stop, full, pflip);
    send_frame(d, stop, pflip);
  endtask

  initial begin
    logic [7:0] d;
    logic       s, f, p;
    int         gap;

    u_if.full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:wr_en",     u_if.wr_en,     1'b0);
    chk("rst:data",      u_if.data,      8'h00);
    chk("rst:frame_err", u_if.frame_err, 1'b0);
    chk("rst:overrun",   u_if.overrun,   1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: clean frame
    frame(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_all("t1");

    // 2: short low glitch is rejected, following frame still lands
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check_all("t2_glitch");
    frame(8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_all("t2_frame");

    // 3: bad stop then line stuck low: one frame error, no retrigger
    frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_all("t3_ferr");
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check_all("t3_noretrig");

    // 4: FIFO full drops the byte
    frame(8'h55, 1'b1, 1'b1, 1'b0);
    u_if.full = 1'b0;
    repeat (4) @(negedge clk);
    check_all("t4_overrun");

    // 5: back-to-back frames, zero idle gap
    frame(8'h00, 1'b1, 1'b0, 1'b0);
    frame(8'hFF, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_all("t5_b2b");

    // 6: reset during data bit 4 discards the partial byte
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
    rxd = 1'b0;
    repeat (BC / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6:wr_en",     u_if.wr_en,     1'b0);
    chk("t6:data",      u_if.data,      8'h00);
    chk("t6:frame_err", u_if.frame_err, 1'b0);
    chk("t6:overrun",   u_if.overrun,   1'b0);
    exp_data = 8'h00;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all("t6_idle");
    frame(8'h81, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check_all("t6_frame");

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 needs parity bit 1, send 0
    frame(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_all("par_err");
`endif

    // randomized frames: byte, FIFO full, stop validity, idle gap
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom_range(0, 255));
      f = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 6) != 0);
      p = 1'b0;
`ifdef UART_RX_PARITY_EN
      p = ($urandom_range(0, 7) == 0);
`endif
      frame(d, s, f, p);
      check_all($sformatf("rnd%0d", n));
      // a bad stop leaves the line low; it must rise before the next start
      gap = s ? int'($urandom_range(0, 20)) : BC;
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
    end
    u_if.full = 1'b0;
    repeat (20) @(negedge clk);
    check_all("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
